pwm_peripheral: RTL and testbench

- Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip output pins.
- Each pin is one of three things: held low, held high, or driven by a shared 8-bit PWM waveform.
- Duty-cycle updates are double-buffered so that no PWM period is ever truncated or glitched.
- Sits directly downstream of the SPI register block, inside the top-level wrapper.

---
 rtl/pwm_peripheral_pkg.sv | 30 +++
 rtl/pwm_peripheral_if.sv | 27 ++
 rtl/pwm_peripheral_timebase.sv | 47 ++++
 rtl/pwm_peripheral.sv | 70 +++++++
 tb/tb_pwm_peripheral.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_peripheral_pkg.sv
// Shared constants, types and helper functions for the PWM pin driver.
package pwm_peripheral_pkg;

  localparam int PWM_CNT_W        = 8;
  localparam int PWM_PERIOD_TICKS = 256;
  localparam int NUM_PINS         = 16;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_PINS-1:0]  pin_vec_t;

  localparam pwm_cnt_t DUTY_FULL = 8'hFF;

  // Waveform level for one counter position. Full scale is special-cased so
  // that 0xFF stays high through pwm_cnt == 255 instead of dropping one tick.
  function automatic logic pwm_level_f(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    if (duty == DUTY_FULL) begin
      return 1'b1;
    end
    return (cnt < duty);
  endfunction

  // Per-pin function: output enable clear wins, then PWM select picks the
  // shared waveform, otherwise the pin is held high.
  function automatic pin_vec_t pin_drive_f(input pin_vec_t en_out,
                                           input pin_vec_t en_pwm,
                                           input logic     level);
    return en_out & (~en_pwm | {NUM_PINS{level}});
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Control-register bundle from the SPI register block into the PWM pin driver.
interface pwm_peripheral_if;
  import pwm_peripheral_pkg::*;

  logic     [7:0] en_reg_out_7_0;
  logic     [7:0] en_reg_out_15_8;
  logic     [7:0] en_reg_pwm_7_0;
  logic     [7:0] en_reg_pwm_15_8;
  pwm_cnt_t       pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_peripheral_timebase.sv
// Prescaler plus 8-bit PWM counter. One PWM period is 256 * CLK_DIV clk cycles.
// CLK_DIV must lie in 1..65535 and fit PRE_W (CLK_DIV <= 2**PRE_W).
module pwm_peripheral_timebase
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int PRE_W   = 16
) (
  input  logic     clk,
  input  logic     rst,
  output logic     tick,
  output logic     wrap,
  output pwm_cnt_t pwm_cnt
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam pwm_cnt_t         CNT_LAST = pwm_cnt_t'(PWM_PERIOD_TICKS - 1);

  logic [PRE_W-1:0] pre_cnt;

  // Tick on the last prescaler state; wrap is the tick that ends a period.
  always_comb begin
    tick = (pre_cnt == PRE_LAST);
    wrap = tick && (pwm_cnt == CNT_LAST);
  end

  // Prescaler counts 0..CLK_DIV-1; with CLK_DIV=1 it sits at 0 and ticks every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // PWM counter advances once per tick and rolls 255 -> 0 without stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + pwm_cnt_t'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives the 16 chip pins low, high or with a shared 8-bit PWM waveform.
// The duty cycle is shadowed and only taken at the period boundary, so a
// period in flight always finishes with the duty it started with.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = 13,
  parameter int PRE_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pwm_peripheral_if.slave   cfg,
  output logic [7:0]        out_7_0,
  output logic [7:0]        out_15_8,
  output logic              period_start
);

  logic     tick;
  logic     wrap;
  pwm_cnt_t pwm_cnt;
  pwm_cnt_t duty_active;
  logic     pwm_level;
  pin_vec_t en_out;
  pin_vec_t en_pwm;
  pin_vec_t drive;

  pwm_peripheral_timebase #(
    .CLK_DIV (CLK_DIV),
    .PRE_W   (PRE_W)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .wrap    (wrap),
    .pwm_cnt (pwm_cnt)
  );

  // Assemble the 16-bit enable vectors and compute the next pin drive.
  always_comb begin
    en_out    = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
    en_pwm    = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};
    pwm_level = pwm_level_f(pwm_cnt, duty_active);
    drive     = pin_drive_f(en_out, en_pwm, pwm_level);
  end

  // Duty shadow: capture the requested duty only on the period-ending tick;
  // whatever is on the input at that edge is what the new period uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active <= '0;
    end else if (tick && wrap) begin
      duty_active <= cfg.pwm_duty_cycle;
    end
  end

  // Registered pin drive and period marker; the marker lands in the clk
  // where pwm_cnt has just rolled to 0, so it never fires out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_7_0      <= '0;
      out_15_8     <= '0;
      period_start <= 1'b0;
    end else begin
      out_7_0      <= drive[7:0];
      out_15_8     <= drive[15:8];
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: static pin table, 50 % waveform timing,
// duty extremes, duty shadowing and asynchronous reset mid-period.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] out_7_0;
  logic [7:0] out_15_8;
  logic       period_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_peripheral_if bus ();

  pwm_peripheral #(
    .CLK_DIV (CLK_DIV),
    .PRE_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (bus),
    .out_7_0      (out_7_0),
    .out_15_8     (out_15_8),
    .period_start (period_start)
  );

  typedef struct {
    logic [7:0] eo_lo;
    logic [7:0] eo_hi;
    logic [7:0] ep_lo;
    logic [7:0] ep_hi;
    logic [7:0] x0_lo;
    logic [7:0] x0_hi;
    logic [7:0] x1_lo;
    logic [7:0] x1_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_cfg(input logic [7:0] eo_lo, input logic [7:0] eo_hi,
                         input logic [7:0] ep_lo, input logic [7:0] ep_hi,
                         input logic [7:0] duty);
    bus.en_reg_out_7_0  = eo_lo;
    bus.en_reg_out_15_8 = eo_hi;
    bus.en_reg_pwm_7_0  = ep_lo;
    bus.en_reg_pwm_15_8 = ep_hi;
    bus.pwm_duty_cycle  = duty;
  endtask

  // Advance at least one clk, then stop on the next period_start sample.
  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < PERIOD + 20);
    if (!period_start) begin
      total++;
      bad++;
      $display("FAIL %s: no period_start within %0d clk", name, n);
    end
  endtask

  // Called on a period_start sample; observes the following PERIOD clks.
  // Optionally writes a new duty at relative clk wr_at.
  task automatic run_period(input int wr_at, input logic [7:0] wr_val,
                            output int hi, output int hi_after,
                            output int first_low, output int ps_at);
    hi = 0; hi_after = 0; first_low = 0; ps_at = 0;
    for (int c = 1; c <= PERIOD; c++) begin
      @(negedge clk);
      if (out_15_8[0] === 1'b1) begin
        hi++;
        if (wr_at != 0 && c > wr_at) hi_after++;
      end else if (first_low == 0) begin
        first_low = c;
      end
      if (period_start === 1'b1 && ps_at == 0) ps_at = c;
      if (c == wr_at) bus.pwm_duty_cycle = wr_val;
    end
  endtask

  initial begin
    int hi, hi_after, first_low, ps_at, mis, ps_n, hi_rst;

    //          eo_lo  eo_hi  ep_lo  ep_hi  x0_lo  x0_hi  x1_lo  x1_hi
    vecs[0] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 8'hFF, 8'hFF};
    vecs[2] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h3C, 8'hC3, 8'hFF, 8'h00, 8'h00, 8'hC3, 8'h3C, 8'hC3};
    vecs[4] = '{8'h81, 8'h7E, 8'h01, 8'h0E, 8'h80, 8'h70, 8'h81, 8'h7E};
    vecs[5] = '{8'h55, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'hAA, 8'h55, 8'hAA};

    rst = 1'b1;
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_out_7_0", out_7_0, 8'h00);
    chk("reset_out_15_8", out_15_8, 8'h00);
    chk("reset_period_start", period_start, 1'b0);
    set_cfg(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("reset_holds_out", {out_15_8, out_7_0}, 16'h0000);
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;

    // Static pin table with the waveform low (duty_active still 0).
    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i].eo_lo, vecs[i].eo_hi, vecs[i].ep_lo, vecs[i].ep_hi, 8'h00);
      @(negedge clk);
      chk($sformatf("tbl0_%0d_lo", i), out_7_0, vecs[i].x0_lo);
      chk($sformatf("tbl0_%0d_hi", i), out_15_8, vecs[i].x0_hi);
    end

    // Static 0xA5 holds for two full periods.
    set_cfg(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("static_lo", out_7_0, 8'hA5);
    chk("static_hi", out_15_8, 8'h00);
    mis = 0;
    for (int c = 0; c < 2 * PERIOD; c++) begin
      @(negedge clk);
      if (out_7_0 !== 8'hA5 || out_15_8 !== 8'h00) mis++;
    end
    chk("static_hold_mismatches", mis, 0);

    // Same table with the waveform pinned high (duty 0xFF active).
    bus.pwm_duty_cycle = 8'hFF;
    wait_ps("ps_full_table");
    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i].eo_lo, vecs[i].eo_hi, vecs[i].ep_lo, vecs[i].ep_hi, 8'hFF);
      @(negedge clk);
      chk($sformatf("tbl1_%0d_lo", i), out_7_0, vecs[i].x1_lo);
      chk($sformatf("tbl1_%0d_hi", i), out_15_8, vecs[i].x1_hi);
    end

    // 50 %: 128 ticks high then 128 low, 3328 clk period.
    set_cfg(8'h00, 8'h01, 8'h00, 8'h01, 8'h80);
    wait_ps("ps_50");
    run_period(0, 8'h00, hi, hi_after, first_low, ps_at);
    chk("half_high_clks", hi, 1664);
    chk("half_first_low", first_low, 1665);
    chk("half_ps_spacing", ps_at, PERIOD);

    // 0x00: never high over three periods.
    bus.pwm_duty_cycle = 8'h00;
    wait_ps("ps_zero");
    for (int p = 0; p < 3; p++) begin
      run_period(0, 8'h00, hi, hi_after, first_low, ps_at);
      chk($sformatf("zero_high_clks_p%0d", p), hi, 0);
      chk($sformatf("zero_ps_spacing_p%0d", p), ps_at, PERIOD);
    end

    // 0xFF: continuously high, no dropout at pwm_cnt 255.
    bus.pwm_duty_cycle = 8'hFF;
    wait_ps("ps_full");
    run_period(0, 8'h00, hi, hi_after, first_low, ps_at);
    chk("full_high_clks", hi, PERIOD);
    chk("full_first_low", first_low, 0);

    // Shadowing: 0x40 active, write 0xC0 at pwm_cnt = 100.
    bus.pwm_duty_cycle = 8'h40;
    wait_ps("ps_shadow");
    run_period(100 * CLK_DIV, 8'hC0, hi, hi_after, first_low, ps_at);
    chk("shadow_old_high_clks", hi, 64 * CLK_DIV);
    chk("shadow_old_first_low", first_low, 64 * CLK_DIV + 1);
    chk("shadow_rest_low", hi_after, 0);
    run_period(0, 8'h00, hi, hi_after, first_low, ps_at);
    chk("shadow_new_high_clks", hi, 192 * CLK_DIV);
    chk("shadow_new_first_low", first_low, 192 * CLK_DIV + 1);

    // Reset at pwm_cnt = 150 with duty 0xC0 active and outputs high.
    bus.en_reg_out_7_0 = 8'hFF;
    repeat (150 * CLK_DIV) @(negedge clk);
    chk("pre_rst_out_7_0", out_7_0, 8'hFF);
    chk("pre_rst_out_15_8", out_15_8, 8'h01);
    #2 rst = 1'b1;
    bus.pwm_duty_cycle = 8'hFF;
    #1;
    chk("async_rst_out_7_0", out_7_0, 8'h00);
    chk("async_rst_out_15_8", out_15_8, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ps_n = 0;
    hi_rst = 0;
    for (int n = 1; n <= PERIOD + 1; n++) begin
      @(negedge clk);
      if (n == 1) chk("post_rst_out_7_0", out_7_0, 8'hFF);
      if (period_start === 1'b1 && ps_n == 0) ps_n = n;
      if (n <= PERIOD && out_15_8[0] !== 1'b0) hi_rst++;
      if (n == PERIOD + 1) chk("post_rst_first_full_high", out_15_8[0], 1'b1);
    end
    chk("post_rst_first_wrap", ps_n, PERIOD);
    chk("post_rst_duty_zero", hi_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
